// File: rtl/ir_key_filter.sv
// NEC key post-processor: validates decoder frames, tracks key hold with a
// timeout and presents each accepted frame as a sticky valid/ack key event.
module ir_key_filter #(
  parameter int unsigned HOLD_TICKS  = 2000000,
  parameter bit          STRICT_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_ready,
  input  logic [31:0] frame_data,
  input  logic        key_ack,
  output logic        key_valid,
  output logic [15:0] key_addr,
  output logic [7:0]  key_code,
  output logic        key_repeat,
  output logic        key_held,
  output logic        overflow,
  output logic        frame_error
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [23:0] HOLD_LOAD = 24'(HOLD_TICKS);

  state_t      state, state_next;
  logic [23:0] cnt, cnt_next;
  logic        ready_q;
  logic        primed;
  logic [15:0] last_addr;
  logic [7:0]  last_code;

  logic [7:0]  f_addr, f_naddr, f_cmd, f_ncmd;
  logic [15:0] new_addr;
  logic        frame_event, accept_event, frame_valid;
  logic        post, bad, match, post_repeat;

  assign f_addr  = frame_data[7:0];
  assign f_naddr = frame_data[15:8];
  assign f_cmd   = frame_data[23:16];
  assign f_ncmd  = frame_data[31:24];

  // The very first ready edge is the decoder's power-up timeout, not a key.
  assign frame_event  = enable & frame_ready & ~ready_q;
  assign accept_event = frame_event & primed;

  assign frame_valid = (f_ncmd == ~f_cmd) && (!STRICT_ADDR || (f_naddr == ~f_addr));
  assign new_addr    = STRICT_ADDR ? {8'h00, f_addr} : frame_data[15:0];

  assign post  = accept_event & frame_valid;
  assign bad   = accept_event & ~frame_valid;
  assign match = (new_addr == last_addr) && (f_cmd == last_code);

  assign key_held = (state == HELD);

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    post_repeat = 1'b0;
    case (state)
      IDLE: begin
        if (post) begin
          state_next = HELD;
          cnt_next   = HOLD_LOAD;
        end
      end
      HELD: begin
        // A rejected frame leaves the hold counter untouched for that cycle.
        if (post) begin
          cnt_next    = HOLD_LOAD;
          post_repeat = match;
        end else if (enable && !bad) begin
          if (cnt <= 24'd1) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - 24'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      primed    <= 1'b0;
      last_addr <= '0;
      last_code <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enable) begin
        ready_q <= frame_ready;
      end
      if (frame_event) begin
        primed <= 1'b1;
      end
      if (post) begin
        last_addr <= new_addr;
        last_code <= f_cmd;
      end
    end
  end

  // A new event always wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid   <= 1'b0;
      key_addr    <= '0;
      key_code    <= '0;
      key_repeat  <= 1'b0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= bad;
      if (post) begin
        key_valid  <= 1'b1;
        key_addr   <= new_addr;
        key_code   <= f_cmd;
        key_repeat <= post_repeat;
        if (key_ack) begin
          overflow <= 1'b0;
        end else if (key_valid) begin
          overflow <= 1'b1;
        end
      end else if (key_ack) begin
        key_valid <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_key_filter.sv
// Self-checking bench for ir_key_filter: directed scenarios plus randomized
// traffic compared against a tick-count based reference model.
module tb_ir_key_filter;

  localparam int HOLD = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame_ready;
  logic [31:0] frame_data;
  logic        key_ack;

  logic        key_valid, key_repeat, key_held, overflow, frame_error;
  logic [15:0] key_addr;
  logic [7:0]  key_code;
  logic        x_key_valid, x_key_repeat, x_key_held, x_overflow, x_frame_error;
  logic [15:0] x_key_addr;
  logic [7:0]  x_key_code;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ir_key_filter #(.HOLD_TICKS(HOLD), .STRICT_ADDR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_ready(frame_ready),
    .frame_data(frame_data), .key_ack(key_ack), .key_valid(key_valid),
    .key_addr(key_addr), .key_code(key_code), .key_repeat(key_repeat),
    .key_held(key_held), .overflow(overflow), .frame_error(frame_error)
  );

  ir_key_filter #(.HOLD_TICKS(HOLD), .STRICT_ADDR(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_ready(frame_ready),
    .frame_data(frame_data), .key_ack(key_ack), .key_valid(x_key_valid),
    .key_addr(x_key_addr), .key_code(x_key_code), .key_repeat(x_key_repeat),
    .key_held(x_key_held), .overflow(x_overflow), .frame_error(x_frame_error)
  );

  // Reference model; index 0 = strict address, 1 = extended address.
  // Hold is tracked as a count of qualifying enabled ticks since the last
  // accepted frame rather than as a down-counter.
  logic        m_ready_q, m_primed;
  int          m_tick[2], m_acc[2];
  bit          m_has[2];
  logic [15:0] m_last_addr[2], m_addr[2];
  logic [7:0]  m_last_code[2], m_code[2];
  logic        m_valid[2], m_rep[2], m_ovf[2], m_err[2];

  function automatic bit m_held(input int s);
    return m_has[s] && ((m_tick[s] - m_acc[s]) < HOLD);
  endfunction

  task automatic model_reset();
    m_ready_q = 1'b0;
    m_primed  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_tick[s] = 0; m_acc[s] = 0; m_has[s] = 1'b0;
      m_last_addr[s] = '0; m_last_code[s] = '0;
      m_valid[s] = 1'b0; m_addr[s] = '0; m_code[s] = '0;
      m_rep[s] = 1'b0; m_ovf[s] = 1'b0; m_err[s] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic        ev, ok, post, rep, was_held;
    logic [15:0] naddr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = enable && frame_ready && !m_ready_q;
    for (int s = 0; s < 2; s++) begin
      ok = (frame_data[31:24] == ~frame_data[23:16]) &&
           ((s == 1) || (frame_data[15:8] == ~frame_data[7:0]));
      naddr = (s == 0) ? {8'h00, frame_data[7:0]} : frame_data[15:0];
      was_held = m_held(s);
      post = 1'b0;
      rep  = 1'b0;
      m_err[s] = 1'b0;
      if (enable) begin
        if (ev && m_primed && !ok) begin
          m_err[s] = 1'b1;
        end else begin
          m_tick[s]++;
          if (ev && m_primed) begin
            post = 1'b1;
            rep = was_held && (naddr == m_last_addr[s]) && (frame_data[23:16] == m_last_code[s]);
            m_last_addr[s] = naddr;
            m_last_code[s] = frame_data[23:16];
            m_has[s] = 1'b1;
            m_acc[s] = m_tick[s];
          end
        end
      end
      if (post) begin
        if (key_ack) m_ovf[s] = 1'b0;
        else if (m_valid[s]) m_ovf[s] = 1'b1;
        m_valid[s] = 1'b1;
        m_addr[s]  = naddr;
        m_code[s]  = frame_data[23:16];
        m_rep[s]   = rep;
      end else if (key_ack) begin
        m_valid[s] = 1'b0;
        m_ovf[s]   = 1'b0;
      end
    end
    if (enable) begin
      if (ev) m_primed = 1'b1;
      m_ready_q = frame_ready;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] d, input logic ack);
    enable = 1'b1; frame_ready = 1'b0; key_ack = 1'b0;
    tick();
    frame_data = d; frame_ready = 1'b1; key_ack = ack;
    tick();
    key_ack = 1'b0;
  endtask

  function automatic logic [31:0] gen_frame(input logic [31:0] prev);
    logic [7:0] a, c, na, nc;
    case ($urandom_range(0, 2))
      0: a = 8'h01;
      1: a = 8'h34;
      default: a = 8'h80;
    endcase
    case ($urandom_range(0, 2))
      0: c = 8'h1C;
      1: c = 8'h45;
      default: c = 8'h46;
    endcase
    na = ~a;
    nc = ~c;
    case ($urandom_range(0, 4))
      0: return prev;
      1: na = 8'($urandom_range(0, 255));
      2: nc = c ^ 8'($urandom_range(1, 255));
      default: ;
    endcase
    return {nc, c, na, a};
  endfunction

  task automatic test_reset();
    checks++;
    if ({key_valid, key_addr, key_code, key_repeat, key_held, overflow, frame_error} !== 29'd0) begin
      fails++;
      $display("[TB] FAIL reset_strict: got %h required 0",
               {key_valid, key_addr, key_code, key_repeat, key_held, overflow, frame_error});
    end
    checks++;
    if ({x_key_valid, x_key_addr, x_key_code, x_key_repeat, x_key_held, x_overflow, x_frame_error} !== 29'd0) begin
      fails++;
      $display("[TB] FAIL reset_ext: got %h required 0",
               {x_key_valid, x_key_addr, x_key_code, x_key_repeat, x_key_held, x_overflow, x_frame_error});
    end
  endtask

  task automatic test_priming();
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_valid, frame_error, key_held} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL priming: valid/err/held got %b required 000", {key_valid, frame_error, key_held});
    end
  endtask

  task automatic test_valid_frame();
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_valid, key_addr, key_code, key_repeat, key_held} !== {1'b1, 16'h0001, 8'h1C, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL valid_frame: valid=%b addr=%h code=%h rep=%b held=%b required 1 0001 1c 0 1",
               key_valid, key_addr, key_code, key_repeat, key_held);
    end
    tick();
    checks++;
    if ({key_valid, key_code} !== {1'b1, 8'h1C}) begin
      fails++;
      $display("[TB] FAIL valid_stable: valid=%b code=%h required 1 1c", key_valid, key_code);
    end
  endtask

  task automatic test_corrupt();
    send_frame(32'hE31DFE01, 1'b0);
    checks++;
    if ({frame_error, key_valid, key_code, key_held} !== {1'b1, 1'b1, 8'h1C, 1'b1}) begin
      fails++;
      $display("[TB] FAIL corrupt: err=%b valid=%b code=%h held=%b required 1 1 1c 1",
               frame_error, key_valid, key_code, key_held);
    end
    tick();
    checks++;
    if (frame_error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL corrupt_pulse_width: err=%b required 0", frame_error);
    end
  endtask

  task automatic test_repeat_hold();
    int cnt;
    repeat (36) tick();
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_repeat, key_held} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL repeat: rep=%b held=%b required 1 1", key_repeat, key_held);
    end
    cnt = 0;
    while (key_held && cnt < 400) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != HOLD) begin
      fails++;
      $display("[TB] FAIL hold_duration: held %0d cycles required %0d", cnt, HOLD);
    end
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_repeat, key_held} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL repeat_after_expiry: rep=%b held=%b required 0 1", key_repeat, key_held);
    end
    cnt = 0;
    while (key_held && cnt < 400) begin
      cnt++;
      enable = (cnt % 2 == 0) ? 1'b1 : 1'b0;
      tick();
    end
    enable = 1'b1;
    checks++;
    if (cnt != 2 * HOLD) begin
      fails++;
      $display("[TB] FAIL hold_half_enable: held %0d cycles required %0d", cnt, 2 * HOLD);
    end
  endtask

  task automatic test_overflow();
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    send_frame(32'hE31CFE01, 1'b0);
    send_frame(32'hBA45FF00, 1'b0);
    checks++;
    if ({key_valid, overflow, key_code, key_addr} !== {1'b1, 1'b1, 8'h45, 16'h0000}) begin
      fails++;
      $display("[TB] FAIL overflow_set: valid=%b ovf=%b code=%h addr=%h required 1 1 45 0000",
               key_valid, overflow, key_code, key_addr);
    end
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    checks++;
    if ({key_valid, overflow} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL ack_clear: valid=%b ovf=%b required 0 0", key_valid, overflow);
    end
    send_frame(32'hE31CFE01, 1'b0);
    send_frame(32'hBA45FF00, 1'b0);
    send_frame(32'hB946FF00, 1'b1);
    checks++;
    if ({key_valid, overflow, key_code} !== {1'b1, 1'b0, 8'h46}) begin
      fails++;
      $display("[TB] FAIL event_with_ack: valid=%b ovf=%b code=%h required 1 0 46",
               key_valid, overflow, key_code);
    end
  endtask

  task automatic test_enable_low();
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    enable = 1'b1; frame_ready = 1'b0; tick();
    enable = 1'b0; frame_data = 32'hE31CFE01; frame_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({key_valid, frame_error} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL disabled_no_detect: valid=%b err=%b required 0 0", key_valid, frame_error);
    end
    enable = 1'b1; tick();
    checks++;
    if ({key_valid, key_code} !== {1'b1, 8'h1C}) begin
      fails++;
      $display("[TB] FAIL detect_on_enable: valid=%b code=%h required 1 1c", key_valid, key_code);
    end
    enable = 1'b0; key_ack = 1'b1; tick(); key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ack_while_disabled: valid=%b required 0", key_valid);
    end
    enable = 1'b1; frame_ready = 1'b0; tick();
    frame_data = 32'hE31DFE01; frame_ready = 1'b1; tick();
    enable = 1'b0;
    checks++;
    if (frame_error !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_enable_error: err=%b required 1", frame_error);
    end
    tick();
    checks++;
    if (frame_error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_enable_error_width: err=%b required 0", frame_error);
    end
    enable = 1'b1;
  endtask

  task automatic test_extended();
    send_frame(32'hE31C1234, 1'b0);
    checks++;
    if (frame_error !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ext_on_strict: err=%b required 1", frame_error);
    end
    checks++;
    if ({x_frame_error, x_key_valid, x_key_addr, x_key_code} !== {1'b0, 1'b1, 16'h1234, 8'h1C}) begin
      fails++;
      $display("[TB] FAIL ext_addr: err=%b valid=%b addr=%h code=%h required 0 1 1234 1c",
               x_frame_error, x_key_valid, x_key_addr, x_key_code);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({key_valid, key_held, overflow, x_key_valid, x_key_held} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL async_reset: got %b required 00000",
               {key_valid, key_held, overflow, x_key_valid, x_key_held});
    end
    tick();
    rst_n = 1'b1;
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_valid, key_held} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reprime: valid=%b held=%b required 0 0", key_valid, key_held);
    end
    send_frame(32'hE31CFE01, 1'b0);
    checks++;
    if ({key_valid, key_repeat, key_held} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL after_reprime: valid=%b rep=%b held=%b required 1 0 1",
               key_valid, key_repeat, key_held);
    end
  endtask

  task automatic test_random();
    int en_pct, tog_pct, ack_pct;
    logic [28:0] exp_v, act_v;
    for (int p = 0; p < 3; p++) begin
      en_pct  = (p == 1) ? 50 : 90;
      tog_pct = (p == 2) ? 2 : 25;
      ack_pct = (p == 0) ? 10 : 30;
      for (int i = 0; i < 800; i++) begin
        enable  = (int'($urandom_range(0, 99)) < en_pct) ? 1'b1 : 1'b0;
        key_ack = (int'($urandom_range(0, 99)) < ack_pct) ? 1'b1 : 1'b0;
        if (int'($urandom_range(0, 99)) < tog_pct) begin
          if (frame_ready) begin
            frame_ready = 1'b0;
          end else begin
            frame_data  = gen_frame(frame_data);
            frame_ready = 1'b1;
          end
        end
        tick();
        exp_v = {m_valid[0], m_addr[0], m_code[0], m_rep[0], m_held(0), m_ovf[0], m_err[0]};
        act_v = {key_valid, key_addr, key_code, key_repeat, key_held, overflow, frame_error};
        checks++;
        if (act_v !== exp_v) begin
          fails++;
          $display("[TB] FAIL random_strict phase %0d cycle %0d: got %h required %h", p, i, act_v, exp_v);
        end
        exp_v = {m_valid[1], m_addr[1], m_code[1], m_rep[1], m_held(1), m_ovf[1], m_err[1]};
        act_v = {x_key_valid, x_key_addr, x_key_code, x_key_repeat, x_key_held, x_overflow, x_frame_error};
        checks++;
        if (act_v !== exp_v) begin
          fails++;
          $display("[TB] FAIL random_ext phase %0d cycle %0d: got %h required %h", p, i, act_v, exp_v);
        end
      end
    end
    key_ack = 1'b0;
    enable  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_ready = 1'b0; frame_data = '0; key_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    test_reset();
    test_priming();
    test_valid_frame();
    test_corrupt();
    test_repeat_hold();
    test_overflow();
    test_enable_low();
    test_extended();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ir_key_filter.md
# ir_key_filter

Post-processing stage that sits directly downstream of the IR pulse decoder. It samples the decoder's 32-bit frame word each time the decoder's idle `ready` flag rises, checks the NEC complement bytes, and tracks key-hold state with a timeout. Each accepted frame becomes a key event, held in a sticky valid/ack output register for the control logic or CPU.

## Interface

- `HOLD_TICKS`, default 2000000: enabled cycles after the last accepted frame before `key_held` drops. Range 1 to 2^24-1.
- `STRICT_ADDR`, default 1: 1 checks the 8-bit address complement (classic NEC); 0 treats `frame_data[15:0]` as a 16-bit address (extended NEC).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  tick qualifier, the same one that drives the decoder.
- `frame_ready`  in  1  decoder idle/ready level.
- `frame_data`  in  32  decoder frame word; bit 0 is the first received bit.
- `key_ack`  in  1  consumer acknowledge.
- `key_valid`  out  1  sticky event-pending flag.
- `key_addr`  out  16  event address.
- `key_code`  out  8  event command byte.
- `key_repeat`  out  1  event is a repeat of the currently held key.
- `key_held`  out  1  a key is considered held.
- `overflow`  out  1  sticky; an event was overwritten before it was acknowledged.
- `frame_error`  out  1  one-cycle pulse on a failed complement check.

## Operation

- **Frame detect.** `ready_q` samples `frame_ready` on enabled cycles. A frame event occurs when `enable & frame_ready & ~ready_q`.
- **Priming.** A `primed` flag starts clear.
  - The first frame event after reset is discarded and sets `primed`. This event is the decoder's power-up idle timeout, and `frame_data` is undefined at that point.
  - No output changes for the discarded event.
- **Fields.** addr = `[7:0]`, naddr = `[15:8]`, cmd = `[23:16]`, ncmd = `[31:24]`.
- **Validation.**
  - The frame is valid if `ncmd == ~cmd`.
  - When `STRICT_ADDR=1`, `naddr == ~addr` is also required.
  - `key_addr` is `{8'h00, addr}` when strict, or `frame_data[15:0]` when not strict.
- **Invalid frame.** Pulse `frame_error` for one cycle. No change to state, counter or key outputs.
- **Hold FSM.** Two states, IDLE and HELD, plus a 24-bit down-counter and stored `last_addr`/`last_code`.
  - IDLE, valid frame: post event with repeat=0, store last, counter=`HOLD_TICKS`, go to HELD.
  - HELD, valid frame matching last: post event with repeat=1, reload counter.
  - HELD, valid frame not matching last: post event with repeat=0, update last, reload counter.
  - HELD, no frame: decrement the counter on each enabled cycle. At the edge where the counter goes 1→0, go to IDLE.
  - `key_held` = (state == HELD).
- **Output handshake.**
  - Post event: load `key_addr`, `key_code` and `key_repeat`, and set `key_valid`.
  - `key_ack` while `key_valid=1`: clear `key_valid` and `overflow`.
  - `key_ack` while `key_valid=0`: ignored.
  - Event while `key_valid=1` and no ack: the newest event overwrites the old one and `overflow` is set.
  - Event and ack in the same cycle: the event wins. The new data is loaded, `key_valid` stays 1 and `overflow` is cleared.
- **`enable` low.**
  - No frame detect, `ready_q` holds, the counter freezes, `frame_error` = 0.
  - `key_ack` is still honoured every cycle.

## Timing

- **Reset values.** All outputs 0. Internally: `ready_q`=0, `primed`=0, counter=0, state IDLE, `last_*`=0.
- **Event latency.** A frame event sampled at clock edge N updates `key_valid`, `key_*` and `frame_error`, visible from edge N.
  - Registered single stage; outputs are stable for the following cycle.
- **`frame_error`.** High for exactly one clock, even when `enable` is high for only one cycle.
- **`key_ack`.** Acting at edge N clears `key_valid` at edge N.
- **Hold duration.** `key_held` stays high for exactly `HOLD_TICKS` enabled cycles after the last accepted frame edge.
  - Disabled cycles do not count.
  - A valid frame on the expiry edge reloads the counter and keeps HELD. If it matches last, repeat=1.
- **Reset mid-operation.** All state clears immediately, including `primed`, so the next frame event is discarded again.

## Test plan

- **Priming.** Release reset, run `enable` every cycle, raise `frame_ready` with `frame_data`=0xE31CFE01 → `key_valid` 0, `frame_error` 0, `key_held` 0.
- **Valid frame.** After priming, drop and re-raise `frame_ready` with 0xE31CFE01 → next cycle: `key_valid` 1, `key_addr` 0x0001, `key_code` 0x1C, `key_repeat` 0, `key_held` 1.
- **Corrupt frame.** Frame 0xE31DFE01 → `frame_error` high for exactly 1 cycle; `key_valid`, `key_code` and `key_held` unchanged.
- **Repeat and hold timeout** (`HOLD_TICKS`=100).
  - Repeat 0xE31CFE01 40 cycles later → `key_repeat` 1.
  - `key_held` falls exactly 100 enabled cycles after the last frame edge.
  - Repeat with `enable` toggling 50% → hold stretches to 200 clocks.
- **Overflow and ack.**
  - Two valid events with no ack → `overflow` 1, `key_code` = second code.
  - Pulse `key_ack` → `key_valid` 0 and `overflow` 0 on the next cycle.
  - Event coincident with ack → `key_valid` stays 1, `overflow` 0, new data loaded.
- **Extended address** (`STRICT_ADDR`=0). Frame 0xE31C1234 → `key_addr` 0x1234, `key_code` 0x1C, no error. The same frame with `STRICT_ADDR`=1 → `frame_error` pulse.
